// File: rtl/maxpool_layer_if.sv
// maxpool_layer_if
//   Streaming handshake between conv_layer output, the pooling block and
//   the next layer.
//   slave  : pooling block view (consumes data_i, produces data_o)
//   master : environment view (drives upstream vectors and downstream ready)
// Signals
//   start_i  frame restart pulse
//   valid_i  upstream vector valid
//   ready_o  block can accept a vector this cycle
//   data_i   upstream vector, lane k at [k*WORD_SIZE +: WORD_SIZE]
//   valid_o  pooled vector valid
//   ready_i  downstream accepts pooled vector
//   data_o   pooled vector, same lane packing
interface maxpool_layer_if #(
    parameter int WORD_SIZE  = 16,
    parameter int N_CHANNELS = 1
);
    logic                               start_i;
    logic                               valid_i;
    logic                               ready_o;
    logic [WORD_SIZE*N_CHANNELS-1:0]    data_i;
    logic                               valid_o;
    logic                               ready_i;
    logic [WORD_SIZE*N_CHANNELS-1:0]    data_o;

    modport slave (
        input  start_i, valid_i, data_i, ready_i,
        output ready_o, valid_o, data_o
    );

    modport master (
        output start_i, valid_i, data_i, ready_i,
        input  ready_o, valid_o, data_o
    );
endinterface

// File: rtl/maxpool_layer.sv
// maxpool_layer
//   Non-overlapping 1-D max pooling (window = stride = POOL_SIZE) over the
//   per-position vectors produced by conv_layer. Each lane is a signed
//   WORD_SIZE value; one pooled vector is emitted per completed window.
//   Vectors past the last full window of a frame are consumed and dropped.
// Ports
//   clk_i    clock, rising edge
//   reset_i  synchronous active-high reset
//   mp       maxpool_layer_if.slave handshake bundle
// Build option
//   MAXPOOL_RELU_EN : clamp negative pooled lanes to zero (fused ReLU).
module maxpool_layer #(
    parameter int WORD_SIZE          = 16,
    parameter int N_CHANNELS         = 1,
    parameter int INPUT_LAYER_HEIGHT = 3,
    parameter int POOL_SIZE          = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    maxpool_layer_if.slave     mp
);
    localparam int DW     = WORD_SIZE * N_CHANNELS;
    localparam int N_OUT  = INPUT_LAYER_HEIGHT / POOL_SIZE;
    localparam int ACTIVE = N_OUT * POOL_SIZE;
    localparam int FW     = $clog2(INPUT_LAYER_HEIGHT + 1);
    localparam int WW     = $clog2(POOL_SIZE + 1);

    localparam logic [FW-1:0] FRAME_LAST = FW'(INPUT_LAYER_HEIGHT - 1);
    localparam logic [FW-1:0] ACTIVE_END = FW'(ACTIVE);
    localparam logic [WW-1:0] WIN_LAST   = WW'(POOL_SIZE - 1);

    logic [FW-1:0] r_frame_cnt;
    logic [WW-1:0] r_win_cnt;
    logic [DW-1:0] r_acc;
    logic [DW-1:0] r_data_o;
    logic          r_valid_o;

    logic          w_accept;
    logic          w_active;
    logic [DW-1:0] w_win_val;
    logic [DW-1:0] w_out;

    // Stall only while a pooled vector is stuck downstream or a restart is in flight.
    assign mp.ready_o = !mp.start_i && !(r_valid_o && !mp.ready_i);
    assign mp.valid_o = r_valid_o;
    assign mp.data_o  = r_data_o;

    assign w_accept = mp.valid_i && mp.ready_o;
    assign w_active = r_frame_cnt < ACTIVE_END;

    // First vector of a window loads directly; later ones keep the larger lane,
    // ties keep the accumulator.
    always_comb begin
        w_win_val = '0;
        w_out     = '0;
        for (int k = 0; k < N_CHANNELS; k++) begin
            if (r_win_cnt == '0 ||
                $signed(mp.data_i[k*WORD_SIZE +: WORD_SIZE]) >
                $signed(r_acc[k*WORD_SIZE +: WORD_SIZE]))
                w_win_val[k*WORD_SIZE +: WORD_SIZE] = mp.data_i[k*WORD_SIZE +: WORD_SIZE];
            else
                w_win_val[k*WORD_SIZE +: WORD_SIZE] = r_acc[k*WORD_SIZE +: WORD_SIZE];
`ifdef MAXPOOL_RELU_EN
            if (w_win_val[k*WORD_SIZE + WORD_SIZE - 1])
                w_out[k*WORD_SIZE +: WORD_SIZE] = '0;
            else
                w_out[k*WORD_SIZE +: WORD_SIZE] = w_win_val[k*WORD_SIZE +: WORD_SIZE];
`else
            w_out[k*WORD_SIZE +: WORD_SIZE] = w_win_val[k*WORD_SIZE +: WORD_SIZE];
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_frame_cnt <= '0;
            r_win_cnt   <= '0;
            r_acc       <= '0;
            r_data_o    <= '0;
            r_valid_o   <= 1'b0;
        end else if (mp.start_i) begin
            r_frame_cnt <= '0;
            r_win_cnt   <= '0;
            r_valid_o   <= 1'b0;
        end else begin
            if (r_valid_o && mp.ready_i)
                r_valid_o <= 1'b0;
            if (w_accept) begin
                // A window completing on the same edge as a transfer overrides
                // the clear above, so back-to-back outputs have no bubble.
                if (w_active) begin
                    r_acc <= w_win_val;
                    if (r_win_cnt == WIN_LAST) begin
                        r_data_o  <= w_out;
                        r_valid_o <= 1'b1;
                        r_win_cnt <= '0;
                    end else begin
                        r_win_cnt <= r_win_cnt + WW'(1);
                    end
                end
                if (r_frame_cnt == FRAME_LAST) begin
                    r_frame_cnt <= '0;
                    r_win_cnt   <= '0;
                end else begin
                    r_frame_cnt <= r_frame_cnt + FW'(1);
                end
            end
        end
    end
endmodule
